// File: rtl/uart_tx_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_arb_pkg
//  Purpose  : Shared definitions for the UART TX round-robin arbiter.
//             - Arbiter state encoding (IDLE / LOCK)
//             - Width helper used for the requester index and the timeout
//               counter widths
//  Revision : 1.0 - initial release
// ============================================================================
package uart_tx_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  // Number of bits needed to index n items, never less than one bit so that
  // degenerate sizes still give a legal vector width.
  function automatic int clog2w(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) begin
      w++;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_arb_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick
//  Purpose  : Combinational round-robin picker. Finds the first set bit of
//             req strictly after position ptr, wrapping modulo RN.
//  Ports    : req [RN] - request vector
//             ptr [RL] - index of the last winner (lowest priority)
//             any      - at least one request is set
//             idx [RL] - winning index (0 when any is low)
//  Revision : 1.0 - initial release
// ============================================================================
module rr_pick
  import uart_tx_arb_pkg::*;
#(
  parameter int RN = 4,
  parameter int RL = clog2w(RN)
) (
  input  logic [RN-1:0] req,
  input  logic [RL-1:0] ptr,
  output logic          any,
  output logic [RL-1:0] idx
);

  logic [RL-1:0] w_cand;

  always_comb begin
    any    = |req;
    idx    = '0;
    w_cand = '0;
    // Walk from the farthest candidate back toward ptr+1; the last hit
    // written is therefore the nearest one after ptr.
    for (int k = RN; k >= 1; k--) begin
      w_cand = RL'((int'(ptr) + k) % RN);
      if (req[w_cand]) begin
        idx = w_cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arb.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_arb
//  Purpose  : Round-robin arbiter sharing one UART TX byte stream among RN
//             requesters. A grant is held for a whole packet (up to tlast),
//             the output is registered, and a requester stalling mid-packet
//             for TO cycles loses its grant (TO = 0 disables this).
//  Ports    : clk, rst                   - clock, synchronous active-high reset
//             req_tvalid/tdata/tlast     - per-requester stream inputs
//             req_tready                 - per-requester ready
//             out_tvalid/tdata, out_tready - stream toward the transmitter
//             gnt_vld, gnt_idx           - current grant
//             abt_pls, abt_idx           - one-cycle abort-by-timeout report
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arb
  import uart_tx_arb_pkg::*;
#(
  parameter int DW = 8,
  parameter int RN = 4,
  parameter int RL = clog2w(RN),
  parameter int TO = 256,
  parameter int TL = clog2w(TO + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RN-1:0]    req_tvalid,
  input  logic [RN*DW-1:0] req_tdata,
  input  logic [RN-1:0]    req_tlast,
  output logic [RN-1:0]    req_tready,
  output logic             out_tvalid,
  output logic [DW-1:0]    out_tdata,
  input  logic             out_tready,
  output logic             gnt_vld,
  output logic [RL-1:0]    gnt_idx,
  output logic             abt_pls,
  output logic [RL-1:0]    abt_idx
);

  arb_state_t    r_state;
  logic          r_out_tvalid;
  logic [DW-1:0] r_out_tdata;
  logic          r_gnt_vld;
  logic [RL-1:0] r_gnt_idx;
  logic [RL-1:0] r_ptr;
  logic          r_abt_pls;
  logic [RL-1:0] r_abt_idx;

  logic          w_any;
  logic [RL-1:0] w_win;
  logic [DW-1:0] w_lane_data [RN];
  logic          w_lane_vld;
  logic          w_lane_last;
  logic          w_out_free;
  logic          w_acc;
  logic          w_to_hit;
  logic [RN-1:0] w_req_tready;

  genvar gi;
  generate
    for (gi = 0; gi < RN; gi++) begin : g_lane
      assign w_lane_data[gi] = req_tdata[gi*DW +: DW];
    end
  endgenerate

  rr_pick #(
    .RN (RN),
    .RL (RL)
  ) u_pick (
    .req (req_tvalid),
    .ptr (r_ptr),
    .any (w_any),
    .idx (w_win)
  );

  assign w_lane_vld  = req_tvalid[r_gnt_idx];
  assign w_lane_last = req_tlast[r_gnt_idx];
  // Output register can take a beat when empty or draining this cycle.
  assign w_out_free  = ~r_out_tvalid | out_tready;
  assign w_acc       = (r_state == LOCK) & w_lane_vld & w_out_free;

  always_comb begin
    w_req_tready = '0;
    if (r_state == LOCK) begin
      w_req_tready[r_gnt_idx] = w_out_free;
    end
  end

  // Stall timer: counts idle cycles of the granted lane. Held at zero outside
  // LOCK, so every new grant starts from zero. A back-pressured lane keeps
  // tvalid high and therefore never advances it.
  generate
    if (TO > 0) begin : g_to
      logic [TL-1:0] r_to_cnt;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_to_cnt <= '0;
        end else if ((r_state != LOCK) || w_acc) begin
          r_to_cnt <= '0;
        end else if (!w_lane_vld) begin
          r_to_cnt <= r_to_cnt + TL'(1);
        end
      end

      assign w_to_hit = (r_state == LOCK) && !w_lane_vld &&
                        (r_to_cnt == TL'(TO - 1));
    end else begin : g_no_to
      assign w_to_hit = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_out_tvalid <= 1'b0;
      r_out_tdata  <= '0;
      r_gnt_vld    <= 1'b0;
      r_gnt_idx    <= '0;
      r_ptr        <= RL'(RN - 1);
      r_abt_pls    <= 1'b0;
      r_abt_idx    <= '0;
    end else begin
      r_abt_pls <= 1'b0;

      if (w_acc) begin
        r_out_tvalid <= 1'b1;
        r_out_tdata  <= w_lane_data[r_gnt_idx];
      end else if (out_tready) begin
        r_out_tvalid <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state   <= LOCK;
            r_gnt_vld <= 1'b1;
            r_gnt_idx <= w_win;
            r_ptr     <= w_win;
          end
        end
        LOCK: begin
          // An accepted tlast excludes an idle lane, so it always wins over
          // the timeout in the same cycle.
          if (w_acc && w_lane_last) begin
            r_state   <= IDLE;
            r_gnt_vld <= 1'b0;
          end else if (w_to_hit) begin
            r_state   <= IDLE;
            r_gnt_vld <= 1'b0;
            r_abt_pls <= 1'b1;
            r_abt_idx <= r_gnt_idx;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign req_tready = w_req_tready;
  assign out_tvalid = r_out_tvalid;
  assign out_tdata  = r_out_tdata;
  assign gnt_vld    = r_gnt_vld;
  assign gnt_idx    = r_gnt_idx;
  assign abt_pls    = r_abt_pls;
  assign abt_idx    = r_abt_idx;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_arb
//  Purpose  : Self-checking bench for uart_tx_arb (DW=8, RN=4, TO=8).
//             Vector table for the single-packet and fairness cases,
//             directed sequences for timeout, back-pressure, reset and
//             tlast-vs-timeout, then a randomized run against a
//             transaction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arb;

  localparam int DW = 8;
  localparam int RN = 4;
  localparam int RL = 2;
  localparam int TO = 8;
  localparam int TL = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [RN-1:0]    vld = '0;
  logic [RN*DW-1:0] dat = '0;
  logic [RN-1:0]    lst = '0;
  logic             ordy = 1'b1;
  logic [RN-1:0]    req_tready;
  logic             out_tvalid;
  logic [DW-1:0]    out_tdata;
  logic             gnt_vld;
  logic [RL-1:0]    gnt_idx;
  logic             abt_pls;
  logic [RL-1:0]    abt_idx;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] sink [$];

  always #5 clk = ~clk;

  uart_tx_arb #(
    .DW (DW),
    .RN (RN),
    .RL (RL),
    .TO (TO),
    .TL (TL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_tvalid (vld),
    .req_tdata  (dat),
    .req_tlast  (lst),
    .req_tready (req_tready),
    .out_tvalid (out_tvalid),
    .out_tdata  (out_tdata),
    .out_tready (ordy),
    .gnt_vld    (gnt_vld),
    .gnt_idx    (gnt_idx),
    .abt_pls    (abt_pls),
    .abt_idx    (abt_idx)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  vld;
    logic [31:0] dat;
    logic [3:0]  lst;
    logic        ordy;
    logic        chk_rdy;
    logic [3:0]  e_rdy;
    logic        e_gv;
    logic [1:0]  e_gi;
    logic        e_ov;
    logic [7:0]  e_od;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t V(input logic r, input logic [3:0] v,
                             input logic [31:0] d, input logic [3:0] l,
                             input logic o, input logic cr,
                             input logic [3:0] er, input logic gv,
                             input logic [1:0] gi, input logic ov,
                             input logic [7:0] od);
    vec_t t;
    t.rst = r; t.vld = v; t.dat = d; t.lst = l; t.ordy = o;
    t.chk_rdy = cr; t.e_rdy = er; t.e_gv = gv; t.e_gi = gi;
    t.e_ov = ov; t.e_od = od;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Record bytes leaving toward the transmitter, then advance one cycle.
  task automatic step();
    if (!rst && out_tvalid && ordy) sink.push_back(out_tdata);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; vld = '0; lst = '0; dat = '0; ordy = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Round-robin reference: first valid index after p, wrapping.
  function automatic int rr_ref(input int p, input logic [3:0] v);
    for (int k = 1; k <= RN; k++) begin
      if (v[(p + k) % RN]) return (p + k) % RN;
    end
    return -1;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  // reference model state for the random run
  logic        m_lock;
  int          m_gi;
  int          m_ptr;
  int          m_cnt;
  logic        m_abt;
  int          m_abt_idx;
  logic [7:0]  m_outq [$];
  logic [3:0]  acc_prev;
  logic [3:0]  e_rdy;
  logic [3:0]  acc;
  int          rem [RN];
  int          seq [RN];
  int          gap [RN];
  logic [3:0]  p_vld;
  logic [3:0]  p_rdy;
  logic [3:0]  p_lst;
  logic [31:0] p_dat;
  logic [7:0]  exp4 [3];

  initial begin
    // ---------------- vector table ----------------
    // single requester 2, 3-byte packet
    tbl.push_back(V(1, 4'b0000, 32'h0, 4'b0000, 1, 0, 4'b0000, 0, 0, 0, 8'h00));
    tbl.push_back(V(0, 4'b0100, 32'h0041_0000, 4'b0000, 1, 1, 4'b0000, 1, 2, 0, 8'h00));
    tbl.push_back(V(0, 4'b0100, 32'h0041_0000, 4'b0000, 1, 1, 4'b0100, 1, 2, 1, 8'h41));
    tbl.push_back(V(0, 4'b0100, 32'h0042_0000, 4'b0000, 1, 1, 4'b0100, 1, 2, 1, 8'h42));
    tbl.push_back(V(0, 4'b0100, 32'h0043_0000, 4'b0100, 1, 1, 4'b0100, 0, 2, 1, 8'h43));
    tbl.push_back(V(0, 4'b0000, 32'h0, 4'b0000, 1, 1, 4'b0000, 0, 2, 0, 8'h00));
    // all four requesters valid, one-byte packets: 0,1,2,3,0,1
    tbl.push_back(V(1, 4'b0000, 32'h0, 4'b0000, 1, 0, 4'b0000, 0, 0, 0, 8'h00));
    for (int p = 0; p < 6; p++) begin
      tbl.push_back(V(0, 4'hF, 32'hA3A2A1A0, 4'hF, 1, 1, 4'h0, 1, 2'(p % 4), 0, 8'h00));
      tbl.push_back(V(0, 4'hF, 32'hA3A2A1A0, 4'hF, 1, 1, 4'(1 << (p % 4)), 0,
                      2'(p % 4), 1, 8'(8'hA0 + (p % 4))));
    end

    @(negedge clk);
    foreach (tbl[n]) begin
      rst = tbl[n].rst; vld = tbl[n].vld; dat = tbl[n].dat;
      lst = tbl[n].lst; ordy = tbl[n].ordy;
      #1;
      if (tbl[n].chk_rdy) chk($sformatf("tbl%0d_req_tready", n), 32'(req_tready), 32'(tbl[n].e_rdy));
      step();
      chk($sformatf("tbl%0d_gnt_vld", n), 32'(gnt_vld), 32'(tbl[n].e_gv));
      chk($sformatf("tbl%0d_gnt_idx", n), 32'(gnt_idx), 32'(tbl[n].e_gi));
      chk($sformatf("tbl%0d_out_tvalid", n), 32'(out_tvalid), 32'(tbl[n].e_ov));
      if (tbl[n].e_ov || tbl[n].rst)
        chk($sformatf("tbl%0d_out_tdata", n), 32'(out_tdata), 32'(tbl[n].e_od));
      chk($sformatf("tbl%0d_abt_pls", n), 32'(abt_pls), 32'd0);
      if (tbl[n].rst) chk($sformatf("tbl%0d_abt_idx", n), 32'(abt_idx), 32'd0);
    end
    rst = 1'b0;

    // ---------------- timeout abort of requester 1 ----------------
    do_reset();
    vld = 4'b0010; dat = 32'h0000_1000; lst = '0; ordy = 1'b1;
    step();
    chk("t3_gnt_idx", 32'(gnt_idx), 32'd1);
    #1 chk("t3_rdy", 32'(req_tready), 32'h2);
    step();
    chk("t3_first_byte", 32'(out_tdata), 32'h10);
    vld = 4'b0100; dat = 32'h0020_0000; lst = 4'b0100;
    for (int k = 1; k <= 8; k++) begin
      #1 chk("t3_pending_rdy2", 32'(req_tready[2]), 32'd0);
      step();
      if (k < 8) begin
        chk("t3_no_abt_early", 32'(abt_pls), 32'd0);
        chk("t3_grant_held", 32'(gnt_vld), 32'd1);
      end else begin
        chk("t3_abt_pls", 32'(abt_pls), 32'd1);
        chk("t3_abt_idx", 32'(abt_idx), 32'd1);
        chk("t3_released", 32'(gnt_vld), 32'd0);
      end
    end
    step();
    chk("t3_abt_one_cycle", 32'(abt_pls), 32'd0);
    chk("t3_next_gnt_vld", 32'(gnt_vld), 32'd1);
    chk("t3_next_gnt_idx", 32'(gnt_idx), 32'd2);
    step();
    chk("t3_lane2_byte", 32'(out_tdata), 32'h20);
    chk("t3_lane2_done", 32'(gnt_vld), 32'd0);

    // ---------------- back-pressure, no abort ----------------
    do_reset();
    sink.delete();
    vld = 4'b0001; dat = 32'h55; lst = '0; ordy = 1'b0;
    step();
    step();
    chk("t4_loaded", 32'(out_tvalid), 32'd1);
    dat = 32'h56;
    for (int k = 0; k < 20; k++) begin
      #1 chk("t4_rdy_blocked", 32'(req_tready[0]), 32'd0);
      step();
      chk("t4_no_abt", 32'(abt_pls), 32'd0);
      chk("t4_data_stable", 32'(out_tdata), 32'h55);
    end
    chk("t4_still_granted", 32'(gnt_vld), 32'd1);
    ordy = 1'b1;
    #1 chk("t4_rdy_resume", 32'(req_tready[0]), 32'd1);
    step();
    chk("t4_byte56", 32'(out_tdata), 32'h56);
    dat = 32'h57; lst = 4'b0001;
    step();
    chk("t4_byte57", 32'(out_tdata), 32'h57);
    chk("t4_eop", 32'(gnt_vld), 32'd0);
    vld = '0; lst = '0;
    step();
    chk("t4_drained", 32'(out_tvalid), 32'd0);
    exp4[0] = 8'h55; exp4[1] = 8'h56; exp4[2] = 8'h57;
    chk("t4_byte_count", 32'(sink.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < sink.size()) chk($sformatf("t4_sink%0d", i), 32'(sink[i]), 32'(exp4[i]));
    end

    // ---------------- reset mid-packet ----------------
    do_reset();
    vld = 4'b1000; dat = 32'h3300_0000; lst = '0; ordy = 1'b0;
    step();
    chk("t5_gnt3", 32'(gnt_idx), 32'd3);
    step();
    chk("t5_held", 32'(out_tvalid), 32'd1);
    rst = 1'b1; vld = 4'b1001; dat = 32'h3300_0001;
    step();
    chk("t5_rst_outv", 32'(out_tvalid), 32'd0);
    chk("t5_rst_gnt", 32'(gnt_vld), 32'd0);
    chk("t5_rst_data", 32'(out_tdata), 32'd0);
    rst = 1'b0;
    step();
    chk("t5_regnt_vld", 32'(gnt_vld), 32'd1);
    chk("t5_regnt_idx0", 32'(gnt_idx), 32'd0);

    // ---------------- tlast at timeout expiry ----------------
    do_reset();
    vld = 4'b0001; dat = 32'h60; lst = '0; ordy = 1'b1;
    step();
    step();
    chk("t6_first", 32'(out_tdata), 32'h60);
    vld = '0;
    for (int k = 1; k <= 7; k++) begin
      step();
      chk("t6_no_abt_wait", 32'(abt_pls), 32'd0);
    end
    vld = 4'b0001; dat = 32'h61; lst = 4'b0001;
    step();
    chk("t6_no_abt_eop", 32'(abt_pls), 32'd0);
    chk("t6_eop", 32'(gnt_vld), 32'd0);
    chk("t6_last_byte", 32'(out_tdata), 32'h61);
    vld = '0; lst = '0;
    step();
    chk("t6_no_abt_after", 32'(abt_pls), 32'd0);

    // ---------------- randomized run vs reference model ----------------
    do_reset();
    sink.delete();
    m_lock = 1'b0; m_gi = 0; m_ptr = RN - 1; m_cnt = 0;
    m_abt = 1'b0; m_abt_idx = 0; m_outq.delete();
    vld = '0; lst = '0; dat = '0; acc_prev = '0;
    p_vld = '0; p_rdy = '0; p_lst = '0; p_dat = '0;
    for (int i = 0; i < RN; i++) begin
      rem[i] = 0; seq[i] = 0; gap[i] = 0;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      chk("rnd_gnt_vld", 32'(gnt_vld), 32'(m_lock));
      chk("rnd_gnt_idx", 32'(gnt_idx), 32'(m_gi));
      chk("rnd_out_tvalid", 32'(out_tvalid), 32'(m_outq.size() != 0));
      if (m_outq.size() != 0) chk("rnd_out_tdata", 32'(out_tdata), 32'(m_outq[0]));
      chk("rnd_abt_pls", 32'(abt_pls), 32'(m_abt));
      if (m_abt) chk("rnd_abt_idx", 32'(abt_idx), 32'(m_abt_idx));

      for (int i = 0; i < RN; i++) begin
        if (acc_prev[i]) begin
          rem[i]--;
          seq[i]++;
        end
        if (vld[i] && !acc_prev[i]) begin
          // pending beat: hold it unchanged
        end else if (gap[i] > 0) begin
          gap[i]--;
          vld[i] = 1'b0;
        end else if ($urandom_range(0, 99) < ((rem[i] > 0) ? 85 : 35)) begin
          if (rem[i] == 0) rem[i] = $urandom_range(1, 4);
          vld[i] = 1'b1;
          dat[i*8 +: 8] = 8'(i * 64 + seq[i] % 64);
          lst[i] = (rem[i] == 1);
        end else begin
          vld[i] = 1'b0;
          if (rem[i] > 0 && $urandom_range(0, 99) < 8) gap[i] = 12;
        end
      end
      ordy = ($urandom_range(0, 99) < 70);
      #1;

      for (int i = 0; i < RN; i++) begin
        if (p_vld[i] && !p_rdy[i] && vld[i])
          chk("rnd_stable", {23'd0, lst[i], dat[i*8 +: 8]}, {23'd0, p_lst[i], p_dat[i*8 +: 8]});
      end

      e_rdy = '0;
      if (m_lock && (m_outq.size() == 0 || ordy)) e_rdy[m_gi] = 1'b1;
      chk("rnd_req_tready", 32'(req_tready), 32'(e_rdy));
      p_vld = vld; p_rdy = req_tready; p_lst = lst; p_dat = dat;

      acc = e_rdy & vld;
      acc_prev = acc;
      if (ordy && m_outq.size() != 0) void'(m_outq.pop_front());
      if (acc != 0) m_outq.push_back(dat[m_gi*8 +: 8]);
      m_abt = 1'b0;
      if (!m_lock) begin
        if (vld != 0) begin
          m_gi = rr_ref(m_ptr, vld);
          m_ptr = m_gi;
          m_lock = 1'b1;
          m_cnt = 0;
        end
      end else if (acc[m_gi]) begin
        if (lst[m_gi]) m_lock = 1'b0;
        m_cnt = 0;
      end else if (!vld[m_gi]) begin
        if (m_cnt == TO - 1) begin
          m_lock = 1'b0;
          m_abt = 1'b1;
          m_abt_idx = m_gi;
        end else begin
          m_cnt++;
        end
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
